// File: rtl/input_conditioner.sv
// input_conditioner: synchronise, debounce and edge-detect slow external
// inputs (buttons, slide switches) ahead of the SoC. Each channel has its own
// flop-chain synchroniser and stability counter. The block produces
// registered one-cycle rise/fall pulses and a masked interrupt pulse.

module input_conditioner #(
    parameter int                NUM_IN          = 17,
    parameter int                SYNC_STAGES     = 2,
    parameter int                DEBOUNCE_CYCLES = 1000000,
    parameter logic [NUM_IN-1:0] RESET_VAL       = '0,
    parameter logic [NUM_IN-1:0] IRQ_MASK        = NUM_IN'(1) << (NUM_IN - 1)
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [NUM_IN-1:0] raw_i,
    output logic [NUM_IN-1:0] stable_o,
    output logic [NUM_IN-1:0] rise_o,
    output logic [NUM_IN-1:0] fall_o,
    output logic              irq_o
);

    // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit so
    // the DEBOUNCE_CYCLES=1 case still elaborates.
    localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_IN-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IN-1:0] sync;

    logic [CNT_W-1:0]  cnt_q  [NUM_IN];
    logic [CNT_W-1:0]  cnt_d  [NUM_IN];
    logic [NUM_IN-1:0] stable_q, stable_d;
    logic [NUM_IN-1:0] rise_q,   rise_d;
    logic [NUM_IN-1:0] fall_q,   fall_d;

    // Synchroniser chain: pure flop-to-flop, no logic between stages.
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's old value and the chain shifts by one.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= RESET_VAL;
            end
        end else begin
            sync_q[0] <= raw_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Only the last stage is allowed to feed any logic.
    assign sync = sync_q[SYNC_STAGES-1];

    // Per-channel debounce decision: clear on agreement, count on
    // disagreement, accept and pulse once the count saturates.
    // NOTE: every output gets a default before the loop; without the
    // defaults this block would infer latches for the untouched paths.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sync[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync[i];
                cnt_d[i]    = '0;
                rise_d[i]   = sync[i];
                fall_d[i]   = ~sync[i];
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Debounce state and registered edge pulses.
    // NOTE: the counter array is control state, not data storage, so it is
    // reset. A reset mid-count must discard partial progress.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < NUM_IN; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q <= RESET_VAL;
            rise_q   <= '0;
            fall_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

    // Derived only from registered pulses, so the interrupt cannot glitch.
    assign irq_o = |(rise_q & IRQ_MASK);

endmodule

// File: tb/tb_input_conditioner.sv
// Testbench for input_conditioner. It runs the small configuration
// (4 channels, 2-stage synchroniser, 4-cycle debounce, button on bit 3).
// Stimulus tasks push expected pulse events into a scoreboard queue. The
// per-cycle monitor pops and compares them when they fall due.

module tb_input_conditioner;

    localparam int          N   = 4;
    localparam int          SS  = 2;
    localparam int          DC  = 4;
    localparam logic [N-1:0] RV = 4'b0000;
    localparam logic [N-1:0] IM = 4'b1000;
    // Raw change after edge k is first seen by edge k+1 (relative edge 0);
    // acceptance happens at relative edge SS+DC-1.
    localparam int          LAT = SS + DC - 1;

    logic         clk_i;
    logic         arst_n_i;
    logic [N-1:0] raw_i;
    logic [N-1:0] stable_o;
    logic [N-1:0] rise_o;
    logic [N-1:0] fall_o;
    logic         irq_o;

    typedef struct {
        int           edge_no;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] stable;
        logic         irq;
    } ev_t;

    ev_t          sb [$];
    logic [N-1:0] exp_stable;
    int           edge_cnt;
    int           errors;
    int           checks;

    input_conditioner #(
        .NUM_IN          (N),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC),
        .RESET_VAL       (RV),
        .IRQ_MASK        (IM)
    ) dut (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .raw_i    (raw_i),
        .stable_o (stable_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .irq_o    (irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Queue an expected acceptance for a raw change driven right now.
    task automatic expect_event(input logic [N-1:0] rise, input logic [N-1:0] fall,
                                input logic [N-1:0] stable, input logic irq);
        ev_t e;
        e.edge_no = edge_cnt + 1 + LAT;
        e.rise    = rise;
        e.fall    = fall;
        e.stable  = stable;
        e.irq     = irq;
        sb.push_back(e);
    endtask

    // Advance n clock edges, sampling 1 ns after each edge and comparing
    // against the scoreboard (pulse cycle) or the idle expectation.
    task automatic advance(input int n);
        ev_t e;
        repeat (n) begin
            @(posedge clk_i);
            #1;
            edge_cnt++;
            while (sb.size() > 0 && sb[0].edge_no < edge_cnt) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event: expected pulse at edge %0d rise=%b fall=%b was never sampled",
                         e.edge_no, e.rise, e.fall);
            end
            if (sb.size() > 0 && sb[0].edge_no == edge_cnt) begin
                e = sb.pop_front();
                exp_stable = e.stable;
                checks++;
                if ({stable_o, rise_o, fall_o, irq_o} !== {e.stable, e.rise, e.fall, e.irq}) begin
                    errors++;
                    $display("FAIL event@%0d: got stable=%b rise=%b fall=%b irq=%b, want stable=%b rise=%b fall=%b irq=%b",
                             edge_cnt, stable_o, rise_o, fall_o, irq_o,
                             e.stable, e.rise, e.fall, e.irq);
                end
            end else begin
                checks++;
                if ({stable_o, rise_o, fall_o, irq_o} !== {exp_stable, {N{1'b0}}, {N{1'b0}}, 1'b0}) begin
                    errors++;
                    $display("FAIL idle@%0d: got stable=%b rise=%b fall=%b irq=%b, want stable=%b and no pulse",
                             edge_cnt, stable_o, rise_o, fall_o, irq_o, exp_stable);
                end
            end
        end
    endtask

    // Reset with all raw pins high, then release and expect a 4'hF rise.
    task automatic test_reset();
        arst_n_i   = 1'b0;
        raw_i      = 4'hF;
        exp_stable = RV;
        #2;
        checks++;
        if ({stable_o, rise_o, fall_o, irq_o} !== {RV, 4'h0, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got stable=%b rise=%b fall=%b irq=%b, want all zero",
                     stable_o, rise_o, fall_o, irq_o);
        end
        advance(3);
        arst_n_i = 1'b1;
        expect_event(4'hF, 4'h0, 4'hF, 1'b1);
        advance(LAT + 3);
    endtask

    // Drop everything, then a clean 0->1 on unmasked channel 0.
    task automatic test_clean_step();
        raw_i = 4'h0;
        expect_event(4'h0, 4'hF, 4'h0, 1'b0);
        advance(LAT + 3);
        raw_i = 4'b0001;
        expect_event(4'b0001, 4'h0, 4'b0001, 1'b0);
        advance(LAT + 3);
    endtask

    // Three-cycle pulse on the button must never be accepted.
    task automatic test_glitch();
        raw_i = 4'b1001;
        advance(3);
        raw_i = 4'b0001;
        advance(LAT + 3);
        checks++;
        if (stable_o[3] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_stable: got stable_o[3]=%b, want 0", stable_o[3]);
        end
    endtask

    // Bouncing button: only the final stable run produces one rise + irq.
    task automatic test_bounce();
        logic [8:0] seq;
        seq = 9'b1_1110_1101;   // bit 0 applied first: 1,0,1,1,0,1,1,1,1
        for (int k = 0; k < 9; k++) begin
            raw_i[3] = seq[k];
            if (k == 5) expect_event(4'b1000, 4'h0, 4'b1001, 1'b1);
            advance(1);
        end
        advance(LAT + 2);
    endtask

    // Channels 1 and 2 rise together, then fall together.
    task automatic test_simultaneous();
        raw_i = 4'b1111;
        expect_event(4'b0110, 4'h0, 4'b1111, 1'b0);
        advance(LAT + 3);
        raw_i = 4'b1001;
        expect_event(4'h0, 4'b0110, 4'b1001, 1'b0);
        advance(LAT + 3);
        checks++;
        if (stable_o !== 4'b1001) begin
            errors++;
            $display("FAIL simul_final: got stable=%b, want 1001", stable_o);
        end
    endtask

    // Staggered acceptances two cycles apart stay separate pulses.
    task automatic test_back_to_back();
        raw_i = 4'b1000;
        expect_event(4'h0, 4'b0001, 4'b1000, 1'b0);
        advance(2);
        raw_i = 4'b0000;
        expect_event(4'h0, 4'b1000, 4'b0000, 1'b0);
        advance(LAT + 3);
    endtask

    // Reset three cycles into a count: no pulse, then full latency again.
    task automatic test_mid_reset();
        raw_i = 4'b0001;
        expect_event(4'b0001, 4'h0, 4'b0001, 1'b0);
        advance(3);
        arst_n_i = 1'b0;
        sb.delete();
        exp_stable = RV;
        #1;
        checks++;
        if ({stable_o, rise_o, fall_o, irq_o} !== {RV, 4'h0, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_clear: got stable=%b rise=%b fall=%b irq=%b, want all zero",
                     stable_o, rise_o, fall_o, irq_o);
        end
        advance(2);
        arst_n_i = 1'b1;
        expect_event(4'b0001, 4'h0, 4'b0001, 1'b0);
        advance(LAT + 3);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        edge_cnt = 0;
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_back_to_back();
        test_mid_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover_events: got %0d pending, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
